// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel operator flow-control wrapper.
package sobel_pkg;

  typedef logic [7:0] mag_t;

  localparam mag_t MAG_MAX    = 8'hFF;
  localparam mag_t MAG_BORDER = 8'h00;

  typedef struct packed {
    logic sof;
    logic eol;
    logic border;
  } sobel_tag_t;

  typedef struct packed {
    mag_t mag;
    logic sof;
    logic eol;
  } sobel_out_t;

endpackage

// File: rtl/sobel_out_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
module sobel_out_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && count_q == CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(pop && count_q == '0));

endmodule

// File: rtl/sobel_pipe_ctrl.sv
// Valid/ready wrapper around the fixed-latency sobel_operator with tagged, credit-managed output FIFO.
// Optional binary edge-map output enabled by defining SOBEL_THRESH_EN (adds the thresh port).
module sobel_pipe_ctrl
  import sobel_pkg::*;
#(
  parameter int unsigned PRECISION  = 16,
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned IMG_W      = 640,
  parameter int unsigned IMG_H      = 480
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [PRECISION-1:0] in_vert,
  input  logic signed [PRECISION-1:0] in_horz,
  output logic signed [PRECISION-1:0] op_vert_out,
  output logic signed [PRECISION-1:0] op_horz_out,
  input  logic [7:0]                  op_mag_in,
  output logic                        out_valid,
  input  logic                        out_ready,
`ifdef SOBEL_THRESH_EN
  input  logic [7:0]                  thresh,
`endif
  output logic [7:0]                  out_mag,
  output logic                        out_sof,
  output logic                        out_eol,
  output logic                        busy
);

  localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  logic [XW-1:0]        x_q, x_d;
  logic [YW-1:0]        y_q, y_d;
  logic [LATENCY-1:0]   vld_q, vld_d;
  sobel_tag_t           tag_q [LATENCY];
  sobel_tag_t           tag_d [LATENCY];
  logic [CW-1:0]        inflight_q, inflight_d;

  logic                 accept;
  logic [CW-1:0]        credits;
  logic [CW-1:0]        fifo_count;
  sobel_tag_t           new_tag;
  sobel_tag_t           tail_tag;
  logic                 tail_vld;
  logic                 pop;
  mag_t                 push_mag;
  sobel_out_t           push_entry;
  sobel_out_t           head_entry;

  // in_ready depends only on registered occupancy so out_ready never reaches it combinationally.
  always_comb begin
    credits  = CW'(FIFO_DEPTH) - fifo_count - inflight_q;
    in_ready = !reset && (credits != '0);
    accept   = in_valid && in_ready;

    op_vert_out = accept ? in_vert : '0;
    op_horz_out = accept ? in_horz : '0;

    new_tag.sof    = (x_q == '0) && (y_q == '0);
    new_tag.eol    = (x_q == X_LAST);
    new_tag.border = (x_q == '0) || (x_q == X_LAST) || (y_q == '0) || (y_q == Y_LAST);

    x_d = x_q;
    y_d = y_q;
    if (accept) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_comb begin
    vld_d    = vld_q;
    tag_d    = tag_q;
    vld_d[0] = accept;
    tag_d[0] = new_tag;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end

    tail_vld = vld_q[LATENCY-1];
    tail_tag = tag_q[LATENCY-1];

    inflight_d = inflight_q;
    if (accept && !tail_vld)      inflight_d = inflight_q + CW'(1);
    else if (!accept && tail_vld) inflight_d = inflight_q - CW'(1);

`ifdef SOBEL_THRESH_EN
    push_mag = tail_tag.border ? MAG_BORDER : ((op_mag_in >= thresh) ? MAG_MAX : MAG_BORDER);
`else
    push_mag = tail_tag.border ? MAG_BORDER : op_mag_in;
`endif
    push_entry.mag = push_mag;
    push_entry.sof = tail_tag.sof;
    push_entry.eol = tail_tag.eol;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q        <= '0;
      y_q        <= '0;
      vld_q      <= '0;
      inflight_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) tag_q[i] <= '0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      vld_q      <= vld_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
    end
  end

  sobel_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(sobel_out_t))
  ) u_out_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tail_vld),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head_entry),
    .count (fifo_count)
  );

  always_comb begin
    out_valid = !reset && (fifo_count != '0);
    pop       = out_valid && out_ready;
    out_mag   = head_entry.mag;
    out_sof   = head_entry.sof;
    out_eol   = head_entry.eol;
    busy      = !reset && ((inflight_q != '0) || (fifo_count != '0));
  end

endmodule
